bit_stream_serializer: RTL and testbench
========================================

# bit_stream_serializer

Parallel-to-serial front end for the serial sequence detectors in this codebase, such as the 110110 detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on a single serial line, which drives the detector's `din`. A one-entry holding register lets back-to-back words stream with no idle bit between them, so patterns that straddle word boundaries are presented contiguously to the downstream detector.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is shifted first; 0 = bit 0 is shifted first.
- `IDLE_BIT`, 0: value driven on `ser_bit` whenever `ser_valid` = 0.
- `clk`  input  1  single clock; everything is sampled on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; 0 = reset.
- `s_data`  input  WIDTH  parallel word; sampled when `s_valid && s_ready`.
- `s_valid`  input  1  upstream word available.
- `s_ready`  output  1  block can accept a word this cycle.
- `ser_bit`  output  1  serial bit to the detector's `din`.
- `ser_valid`  output  1  `ser_bit` carries a word bit this cycle.
- `ser_last`  output  1  this is the final bit of the current word.
- `busy`  output  1  shifter or holding register is occupied.

## Operation
- Storage:
  - shift register `sh` (WIDTH), bit counter `cnt` (clog2(WIDTH)), FSM state.
  - holding register `hold` (WIDTH) with flag `hold_full`.
- FSM states:
  - IDLE: shifter empty.
  - SHIFT: word in flight, `cnt` = index of the bit currently driven (0..WIDTH-1).
- `s_ready` = `!hold_full`, forced 0 while `reset` = 0.
- Accept in IDLE: word loads directly into `sh`, `cnt` <= 0, state goes to SHIFT.
- Accept in SHIFT with `cnt` < WIDTH-1: word loads into `hold`, `hold_full` <= 1.
- End of word in SHIFT with `cnt` = WIDTH-1:
  - if `hold_full`: `sh` <= `hold`, `hold_full` <= 0, `cnt` <= 0, stay in SHIFT.
  - else if a word is accepted this cycle: bypass it straight into `sh`, stay in SHIFT.
  - else: go to IDLE.
- Output bit: `ser_bit` = `sh[WIDTH-1]` when MSB_FIRST, else `sh[0]`. Shift left or right accordingly each SHIFT cycle.
- `ser_valid` = (state == SHIFT). `ser_last` = SHIFT && `cnt` == WIDTH-1. `busy` = SHIFT || `hold_full`.
- Outside SHIFT, `ser_bit` = IDLE_BIT. The serial line never carries stale data.
- A word is never dropped or duplicated. When `s_ready` = 0, `s_valid` is ignored and upstream must hold `s_data`.

## Timing
- Reset (async assert): state=IDLE, `hold_full`=0, `cnt`=0, `sh`=0. Outputs: `ser_valid`=0, `ser_last`=0, `ser_bit`=IDLE_BIT, `busy`=0, `s_ready`=0.
- First cycle after reset release: `s_ready`=1.
- Reset mid-word: outputs go idle immediately. The partial word and the held word are discarded, with no completion.
- Latency: a word accepted at edge t drives its first bit during cycle t+1 and its last bit during t+WIDTH.
- Throughput: one word per WIDTH cycles sustained. Continuous `s_valid` gives `ser_valid` high with no gaps.
- Simultaneous accept and end of word with `hold_full`=0: the bypass path is used, so no gap cycle.
- Simultaneous accept and `hold_full`=1: impossible, because `s_ready`=0.

## Structure
- Shared package `ser_pkg`:
  - state enum `ser_state_t` {IDLE, SHIFT}.
  - default width constant `SER_WIDTH_DEF` = 8.
- Sub-module `ser_hold_reg`: one-entry register with load/unload/full. All other logic lives inline.

## Test plan
- Reset: drive `reset`=0 mid-stream -> `ser_valid`=0, `ser_bit`=IDLE_BIT and `s_ready`=0 immediately. After release, `s_ready`=1 and `busy`=0.
- Single word 0xD8, MSB_FIRST=1, accepted at t -> `ser_bit`=1,1,0,1,1,0,0,0 on cycles t+1..t+8, `ser_last` only at t+8. A downstream 110110 detector flags a match.
- Back-to-back 0xB6 then 0xDB with continuous `s_valid` -> 16 contiguous valid bits, no gap. `s_ready` drops to 0 once `hold` is full and rises when it drains.
- MSB_FIRST=0, word 0x1B -> bits 1,1,0,1,1,0,0,0 in order.
- Backpressure: `s_valid` held high while `s_ready`=0 with data changing -> only words sampled on accept edges appear on the serial line, none lost or repeated.
- Reset asserted at `cnt`=3 with `hold_full`=1 -> both words discarded. The next accepted word 0xFF appears cleanly starting one cycle after its accept.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and defaults for the parallel-to-serial front end.
package ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam int unsigned SER_WIDTH_DEF = 8;

   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding register that parks the next word while the shifter is busy.
module ser_hold_reg
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH = SER_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             unload,
   output logic [WIDTH-1:0] data,
   output logic             full
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data <= '0;
         full <= 1'b0;
      end else if (unload) begin
         full <= 1'b0;
      end else if (load) begin
         data <= load_data;
         full <= 1'b1;
      end
   end

endmodule

// File: rtl/bit_stream_serializer.sv
// Streams WIDTH-bit words out one bit per clock; a holding register keeps
// consecutive words contiguous on the serial line.
module bit_stream_serializer
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH     = SER_WIDTH_DEF,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             ser_bit,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy
);

   localparam int unsigned     CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   ser_state_t       state;
   logic [WIDTH-1:0] sh;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic             accept;
   logic             at_last;
   logic             hold_load;
   logic             hold_unload;
   logic [WIDTH-1:0] shifted;

   assign s_ready     = reset & ~hold_full;
   assign accept      = s_valid & s_ready;
   assign at_last     = (state == SHIFT) && (cnt == LAST);
   assign hold_load   = accept && (state == SHIFT) && !at_last;
   assign hold_unload = at_last && hold_full;
   assign shifted     = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

   ser_hold_reg #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk       (clk),
      .reset     (reset),
      .load      (hold_load),
      .load_data (s_data),
      .unload    (hold_unload),
      .data      (hold),
      .full      (hold_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         sh    <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sh    <= s_data;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt == LAST) begin
                  cnt <= '0;
                  // A fresh word arriving on the last bit bypasses hold so no gap appears.
                  if (hold_full) begin
                     sh <= hold;
                  end else if (accept) begin
                     sh <= s_data;
                  end else begin
                     sh    <= '0;
                     state <= IDLE;
                  end
               end else begin
                  sh  <= shifted;
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ser_valid = (state == SHIFT);
   assign ser_last  = at_last;
   assign busy      = (state == SHIFT) | hold_full;
   assign ser_bit   = ser_valid ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: MSB-first and LSB-first instances share stimulus
// and are checked every cycle against a bit-queue model of the serial stream.
module tb_bit_stream_serializer;

   localparam int unsigned W = 8;

   logic         clk;
   logic         reset;
   logic [W-1:0] s_data;
   logic         s_valid;
   logic         s_ready_m, ser_bit_m, ser_valid_m, ser_last_m, busy_m;
   logic         s_ready_l, ser_bit_l, ser_valid_l, ser_last_l, busy_l;

   int checks   = 0;
   int failures = 0;

   bit qm[$];
   bit ql[$];
   int mn;
   bit macc;

   logic [15:0] cv_m, cv_l, cv_last, cv_valid, cv_rdy;

   bit_stream_serializer #(
      .WIDTH     (W),
      .MSB_FIRST (1'b1),
      .IDLE_BIT  (1'b0)
   ) dut_msb (
      .clk       (clk),
      .reset     (reset),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready_m),
      .ser_bit   (ser_bit_m),
      .ser_valid (ser_valid_m),
      .ser_last  (ser_last_m),
      .busy      (busy_m)
   );

   bit_stream_serializer #(
      .WIDTH     (W),
      .MSB_FIRST (1'b0),
      .IDLE_BIT  (1'b1)
   ) dut_lsb (
      .clk       (clk),
      .reset     (reset),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready_l),
      .ser_bit   (ser_bit_l),
      .ser_valid (ser_valid_l),
      .ser_last  (ser_last_l),
      .busy      (busy_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the block is a FIFO of bits; at most one waiting word beyond the one in flight.
   always @(negedge reset) begin
      qm.delete();
      ql.delete();
   end

   always @(posedge clk) begin
      if (!reset) begin
         qm.delete();
         ql.delete();
      end else begin
         macc = s_valid && (qm.size() <= W);
         if (qm.size() > 0) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
         end
         if (macc) begin
            for (int i = 0; i < W; i++) begin
               qm.push_back(s_data[W-1-i]);
               ql.push_back(s_data[i]);
            end
         end
      end
   end

   always @(negedge clk) begin
      mn = qm.size();
      check("m_valid", ser_valid_m, (mn > 0));
      check("l_valid", ser_valid_l, (mn > 0));
      check("m_bit",   ser_bit_m,   (mn > 0) ? qm[0] : 1'b0);
      check("l_bit",   ser_bit_l,   (mn > 0) ? ql[0] : 1'b1);
      check("m_last",  ser_last_m,  (mn > 0) && ((mn - 1) % W == 0));
      check("l_last",  ser_last_l,  (mn > 0) && ((mn - 1) % W == 0));
      check("m_ready", s_ready_m,   reset && (mn <= W));
      check("l_ready", s_ready_l,   reset && (mn <= W));
      check("m_busy",  busy_m,      (mn > 0));
      check("l_busy",  busy_l,      (mn > 0));
   end

   task automatic send(input logic [W-1:0] w);
      bit rdy;
      bit ok;
      ok      = 1'b0;
      s_data  = w;
      s_valid = 1'b1;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk) rdy = s_ready_m;
         @(posedge clk);
         #1;
         if (rdy) ok = 1'b1;
      end
      s_valid = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout word=%0h actual=not_accepted expected=accepted", w);
      end
   endtask

   task automatic collect(input int n);
      cv_m = '0; cv_l = '0; cv_last = '0; cv_valid = '0; cv_rdy = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cv_m     = {cv_m[14:0], ser_bit_m};
         cv_l     = {cv_l[14:0], ser_bit_l};
         cv_last  = {cv_last[14:0], ser_last_m};
         cv_valid = {cv_valid[14:0], ser_valid_m};
         cv_rdy   = {cv_rdy[14:0], s_ready_m};
      end
   endtask

   initial begin
      int nl;
      int nv;
      bit idle;
      reset   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      #1;
      check("rst_ready", s_ready_m, 1'b0);
      check("rst_valid", ser_valid_m, 1'b0);
      check("rst_bit_l", ser_bit_l, 1'b1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("post_rst_ready", s_ready_m, 1'b1);
      check("post_rst_busy", busy_m, 1'b0);
      @(posedge clk); #1;

      // Single word 0xD8: MSB line 11011000, LSB line 00011011
      send(8'hD8);
      collect(8);
      check("d8_msb_bits", cv_m[7:0], 8'hD8);
      check("d8_lsb_bits", cv_l[7:0], 8'h1B);
      check("d8_last", cv_last[7:0], 8'h01);
      check("d8_valid", cv_valid[7:0], 8'hFF);
      check("d8_detect_110110", (cv_m[7:2] == 6'b110110), 1'b1);
      @(negedge clk);
      check("d8_idle_after", ser_valid_m, 1'b0);
      @(posedge clk); #1;

      send(8'h1B);
      collect(8);
      check("1b_lsb_bits", cv_l[7:0], 8'hD8);
      check("1b_msb_bits", cv_m[7:0], 8'h1B);
      @(posedge clk); #1;

      // Back-to-back words through the holding register
      send(8'hB6);
      fork
         collect(16);
         send(8'hDB);
      join
      check("b2b_msb_bits", cv_m, 16'hB6DB);
      check("b2b_lsb_bits", cv_l, 16'h6DDB);
      check("b2b_valid", cv_valid, 16'hFFFF);
      check("b2b_last", cv_last, 16'h0101);
      check("b2b_ready", cv_rdy, 16'h80FF);
      @(posedge clk); #1;

      // Backpressure: valid held high with data changing every cycle
      nl = 0;
      nv = 0;
      s_valid = 1'b1;
      s_data  = 8'h40;
      for (int i = 1; i <= 70; i++) begin
         @(negedge clk);
         nl += int'(ser_last_m);
         nv += int'(ser_valid_m);
         @(posedge clk);
         #1;
         if (i < 30) s_data = 8'(8'h40 + i);
         else s_valid = 1'b0;
      end
      check("bp_words", nl, 5);
      check("bp_bits", nv, 40);
      idle = 1'b0;
      for (int k = 0; k < 40 && !idle; k++) begin
         @(negedge clk);
         if (!busy_m) idle = 1'b1;
      end
      check("bp_drained", idle, 1'b1);
      @(posedge clk); #1;

      // Reset while cnt = 3 and the holding register is full
      send(8'h5A);
      send(8'h3C);
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst_busy", busy_m, 1'b1);
      check("pre_rst_ready", s_ready_m, 1'b0);
      reset = 1'b0;
      #1;
      check("mid_rst_valid", ser_valid_m, 1'b0);
      check("mid_rst_bit_m", ser_bit_m, 1'b0);
      check("mid_rst_bit_l", ser_bit_l, 1'b1);
      check("mid_rst_ready", s_ready_m, 1'b0);
      check("mid_rst_busy", busy_m, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rel_ready", s_ready_m, 1'b1);
      check("rel_valid", ser_valid_m, 1'b0);
      @(posedge clk); #1;
      send(8'hFF);
      collect(8);
      check("ff_bits", cv_m[7:0], 8'hFF);
      check("ff_valid", cv_valid[7:0], 8'hFF);
      check("ff_last", cv_last[7:0], 8'h01);
      @(negedge clk);
      check("ff_idle_after", ser_valid_m, 1'b0);
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
